// File: rtl/lsu_pkg.sv
// Shared types, widths and byte-enable/alignment helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [BE_W-1:0] byte_enable(size_e size, logic [1:0] addr_lo);
        case (size)
            BYTE:    byte_enable = BE_W'(4'b0001 << addr_lo);
            HALF:    byte_enable = BE_W'(4'b0011 << {addr_lo[1], 1'b0});
            default: byte_enable = BE_W'(4'b1111);
        endcase
    endfunction

    // Bytes never fault; halves need an even address, words a 4-byte boundary.
    function automatic logic misaligned(size_e size, logic [1:0] addr_lo);
        case (size)
            HALF:    misaligned = addr_lo[0];
            WORD:    misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data steering: store replication/byte-enables and load lane extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]      st_size,
    input  logic [1:0]      st_addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      ld_size,
    input  logic [1:0]      ld_addr_lo,
    input  logic            ld_sign,
    input  logic [XLEN-1:0] rdata,
    output logic [BE_W-1:0] be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: replicate the source so every enabled lane carries the data.
    always_comb begin
        be        = byte_enable(size_e'(st_size), st_addr_lo);
        wdata_rep = wdata;
        if (st_size == BYTE) begin
            wdata_rep = {4{wdata[7:0]}};
        end else if (st_size == HALF) begin
            wdata_rep = {2{wdata[15:0]}};
        end
    end

    // Load side: pick the addressed lane, then sign- or zero-extend it.
    always_comb begin
        case (ld_addr_lo)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half   = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        rdata_ext = rdata;
        if (ld_size == BYTE) begin
            rdata_ext = {{24{ld_sign & ld_byte[7]}}, ld_byte};
        end else if (ld_size == HALF) begin
            rdata_ext = {{16{ld_sign & ld_half[15]}}, ld_half};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: stalls the core while one memory access completes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    input  logic             st_en_i,
    input  logic             lb_i,
    input  logic             lh_i,
    input  logic             lbu_i,
    input  logic             lhu_i,
    input  logic             sb_i,
    input  logic             sh_i,
    input  logic [Width-1:0] addr_i,
    input  logic [Width-1:0] wdata_i,
    output logic             stall_o,
    output logic [Width-1:0] rdata_o,
    output logic             rdata_valid_o,
    output logic             misalign_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [Width-1:0] mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    output logic [3:0]       mem_be_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [Width-1:0] mem_rdata_i
);

    state_e            state_q, state_d;
    size_e             size_dec, size_q;
    logic              sign_dec, sign_q;
    logic              mis_dec;
    logic              we_q, err_q;
    logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
    logic [XLEN-1:0]   wdata_rep, rdata_ext;
    logic [BE_W-1:0]   be_q, be_st;

    // Decode size/sign with fixed flag priority; the other direction's flags are ignored.
    always_comb begin
        size_dec = WORD;
        sign_dec = 1'b0;
        if (st_en_i) begin
            if (sb_i)       size_dec = BYTE;
            else if (sh_i)  size_dec = HALF;
        end else begin
            if (lb_i) begin
                size_dec = BYTE;
                sign_dec = 1'b1;
            end else if (lbu_i) begin
                size_dec = BYTE;
            end else if (lh_i) begin
                size_dec = HALF;
                sign_dec = 1'b1;
            end else if (lhu_i) begin
                size_dec = HALF;
            end
        end
        mis_dec = misaligned(size_dec, addr_i[1:0]);
    end

    lsu_align u_align (
        .st_size    (size_dec),
        .st_addr_lo (addr_i[1:0]),
        .wdata      (wdata_i),
        .ld_size    (size_q),
        .ld_addr_lo (addr_q[1:0]),
        .ld_sign    (sign_q),
        .rdata      (mem_rdata_i),
        .be         (be_st),
        .wdata_rep  (wdata_rep),
        .rdata_ext  (rdata_ext)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state and stall decode; stall is forced low under reset.
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o = req_valid_i & rst_ni;
                if (req_valid_i) state_d = mis_dec ? DONE : REQ;
            end
            REQ: begin
                stall_o = 1'b1;
                if (mem_gnt_i) state_d = we_q ? DONE : WAIT_R;
            end
            WAIT_R: begin
                stall_o = 1'b1;
                if (mem_rvalid_i) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the request on acceptance and the extended load data on response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            size_q  <= BYTE;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && req_valid_i) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_rep;
                be_q    <= be_st;
                we_q    <= st_en_i;
                size_q  <= size_dec;
                sign_q  <= sign_dec;
                err_q   <= mis_dec;
            end
            if (state_q == WAIT_R && mem_rvalid_i) begin
                rdata_q <= rdata_ext;
            end
        end
    end

    // Memory request and completion outputs, all decoded from registers.
    assign mem_req_o     = (state_q == REQ);
    assign mem_we_o      = we_q;
    assign mem_addr_o    = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wdata_o   = wdata_q;
    assign mem_be_o      = be_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = (state_q == DONE) && !err_q && !we_q;
    assign misalign_o    = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected transactions queued at issue, checked at completion.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, st_en_i;
    logic        lb_i, lh_i, lbu_i, lhu_i, sb_i, sh_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, misalign_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk_i = ~clk_i;

    load_store_unit #(.Width(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .st_en_i(st_en_i),
        .lb_i(lb_i), .lh_i(lh_i), .lbu_i(lbu_i), .lhu_i(lhu_i), .sb_i(sb_i), .sh_i(sh_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .rdata_o(rdata_o),
        .rdata_valid_o(rdata_valid_o), .misalign_o(misalign_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    // Flag vector layout: {lb, lh, lbu, lhu, sb, sh}. Size: 0 byte, 1 half, 2 word.
    function automatic int m_size(input logic we, input logic [5:0] f);
        if (we) return f[1] ? 0 : (f[0] ? 1 : 2);
        if (f[5] || f[3]) return 0;
        if (f[4] || f[2]) return 1;
        return 2;
    endfunction

    function automatic logic m_signed(input logic we, input logic [5:0] f);
        if (we) return 1'b0;
        if (f[5]) return 1'b1;
        if (f[3]) return 1'b0;
        return f[4];
    endfunction

    function automatic logic m_mis(input int sz, input logic [31:0] a);
        if (sz == 1) return a[0];
        if (sz == 2) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input int sz, input logic [31:0] a);
        if (sz == 2) return 4'hF;
        if (sz == 1) return a[1] ? 4'hC : 4'h3;
        case (a[1:0])
            2'd0: return 4'h1;
            2'd1: return 4'h2;
            2'd2: return 4'h4;
            default: return 4'h8;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input int sz, input logic [31:0] w);
        if (sz == 0) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        if (sz == 1) return {w[15:0], w[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] m_rd(input int sz, input logic sg, input logic [31:0] a,
                                         input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        b = r[int'(a[1:0]) * 8 +: 8];
        h = r[int'(a[1]) * 16 +: 16];
        if (sz == 0) return sg ? {{24{b[7]}}, b} : {24'h0, b};
        if (sz == 1) return sg ? {{16{h[15]}}, h} : {16'h0, h};
        return r;
    endfunction

    // Issue one access, play the memory side with the given delays, then check at completion.
    task automatic access(input logic we, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rvd);
        exp_t e, got;
        int   sz, cyc, gc, rc;
        logic sg, granted, rv_sent, done, saw_req;
        sz = m_size(we, f);
        sg = m_signed(we, f);
        e.we    = we;
        e.addr  = {a[31:2], 2'b00};
        e.be    = m_be(sz, a);
        e.wdata = m_wd(sz, wd);
        e.mis   = m_mis(sz, a);
        e.rdata = m_rd(sz, sg, a, rd);
        e.lat   = e.mis ? 1 : (we ? 2 + gd : 3 + gd + rvd);
        sb_q.push_back(e);

        @(negedge clk_i);
        req_valid_i = 1'b1; st_en_i = we; addr_i = a; wdata_i = wd;
        {lb_i, lh_i, lbu_i, lhu_i, sb_i, sh_i} = f;
        #1;
        n_tests++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_accept addr=%h got=%b want=1", a, stall_o);
        end

        granted = 0; rv_sent = 0; done = 0; saw_req = 0; gc = 0; rc = 0; cyc = 0;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk_i);
            cyc = i;
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
            if (!stall_o) begin
                done = 1;
            end else begin
                if (mem_req_o) begin
                    saw_req = 1;
                    n_tests++;
                    if (mem_addr_o !== e.addr || mem_we_o !== we ||
                        (we && (mem_be_o !== e.be || mem_wdata_o !== e.wdata))) begin
                        n_fail++;
                        $display("FAIL req_fields cyc=%0d got addr=%h be=%h wd=%h we=%b want addr=%h be=%h wd=%h we=%b",
                                 cyc, mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o,
                                 e.addr, e.be, e.wdata, we);
                    end
                end
                if (granted && !we && !rv_sent) begin
                    if (rc == rvd) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = rd;
                        rv_sent      = 1;
                    end else begin
                        rc++;
                        mem_rdata_i = $urandom;
                    end
                end else if (mem_req_o && !granted) begin
                    if (gc == gd) begin
                        mem_gnt_i = 1'b1;
                        granted   = 1;
                    end else begin
                        gc++;
                    end
                end
            end
        end

        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout addr=%h got=no_completion want=completion", a);
            void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty got=0 want=1");
        end else begin
            got = sb_q.pop_front();
            if (cyc != got.lat || rdata_valid_o !== (!got.we && !got.mis) ||
                misalign_o !== got.mis || (!got.we && !got.mis && rdata_o !== got.rdata) ||
                (got.mis && saw_req)) begin
                n_fail++;
                $display("FAIL done addr=%h got lat=%0d rv=%b mis=%b rd=%h req=%b want lat=%0d rv=%b mis=%b rd=%h",
                         a, cyc, rdata_valid_o, misalign_o, rdata_o, saw_req, got.lat,
                         !got.we && !got.mis, got.mis, got.rdata);
            end
        end
        req_valid_i = 1'b0;
        {lb_i, lh_i, lbu_i, lhu_i, sb_i, sh_i} = 6'b0;

        @(negedge clk_i);
        n_tests++;
        if (rdata_valid_o !== 1'b0 || misalign_o !== 1'b0 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_width addr=%h got rv=%b mis=%b stall=%b want 0 0 0",
                     a, rdata_valid_o, misalign_o, stall_o);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_tests++;
        if (stall_o !== 1'b0 || rdata_o !== 32'h0 || rdata_valid_o !== 1'b0 ||
            misalign_o !== 1'b0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0 ||
            mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_be_o !== 4'h0) begin
            n_fail++;
            $display("FAIL %s got stall=%b rd=%h rv=%b mis=%b req=%b we=%b addr=%h wd=%h be=%h want all 0",
                     tag, stall_o, rdata_o, rdata_valid_o, misalign_o, mem_req_o, mem_we_o,
                     mem_addr_o, mem_wdata_o, mem_be_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_valid_i = 1'b1; st_en_i = 1'b1; addr_i = 32'h1234_5678; wdata_i = 32'hFFFF_FFFF;
        {lb_i, lh_i, lbu_i, lhu_i, sb_i, sh_i} = 6'b0;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset_held");
        req_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all_zero("reset_release");
    endtask

    task automatic test_store();
        access(1'b1, 6'b000010, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0);
        access(1'b1, 6'b000001, 32'h0000_1006, 32'h1234_BEEF, 32'h0, 0, 0);
        access(1'b1, 6'b000000, 32'h0000_1008, 32'hCAFE_F00D, 32'h0, 1, 0);
    endtask

    task automatic test_load();
        access(1'b0, 6'b100000, 32'h0000_2001, 32'h0, 32'h0000_80FF, 0, 0);
        access(1'b0, 6'b001000, 32'h0000_2001, 32'h0, 32'h0000_80FF, 0, 0);
        access(1'b0, 6'b010000, 32'h0000_2002, 32'h0, 32'h9234_0000, 0, 0);
        access(1'b0, 6'b000100, 32'h0000_2002, 32'h0, 32'h9234_0000, 0, 0);
        access(1'b0, 6'b000000, 32'h0000_2004, 32'h0, 32'h8765_4321, 3, 2);
    endtask

    task automatic test_misalign();
        access(1'b0, 6'b000000, 32'h0000_2002, 32'h0, 32'hFFFF_FFFF, 0, 0);
        access(1'b0, 6'b010000, 32'h0000_2003, 32'h0, 32'hFFFF_FFFF, 0, 0);
        access(1'b1, 6'b000001, 32'h0000_2001, 32'h5555_AAAA, 32'h0, 0, 0);
        access(1'b1, 6'b000000, 32'h0000_2001, 32'h5555_AAAA, 32'h0, 0, 0);
    endtask

    task automatic test_priority();
        access(1'b0, 6'b111100, 32'h0000_3003, 32'h0, 32'h8000_0000, 0, 0);
        access(1'b0, 6'b011100, 32'h0000_3003, 32'h0, 32'h8000_0000, 0, 0);
        access(1'b0, 6'b010100, 32'h0000_3002, 32'h0, 32'h8000_0000, 0, 0);
        access(1'b0, 6'b000011, 32'h0000_3000, 32'h0, 32'h1357_9BDF, 0, 0);
        access(1'b1, 6'b111111, 32'h0000_3002, 32'h0000_00C3, 32'h0, 0, 0);
        access(1'b1, 6'b111100, 32'h0000_3004, 32'hA5A5_0F0F, 32'h0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [5:0] f;
            f = 6'($urandom_range(0, 63));
            access(1'($urandom_range(0, 1)), f, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
    endtask

    // Reset while waiting for read data; the late response must be dropped.
    task automatic test_reset_mid();
        @(negedge clk_i);
        req_valid_i = 1'b1; st_en_i = 1'b0; addr_i = 32'h0000_4000; wdata_i = 32'h0;
        {lb_i, lh_i, lbu_i, lhu_i, sb_i, sh_i} = 6'b0;
        @(negedge clk_i);
        n_tests++;
        if (mem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_req got=%b want=1", mem_req_o);
        end
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        n_tests++;
        if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait got stall=%b req=%b want 1 0", stall_o, mem_req_o);
        end
        rst_ni = 1'b0;
        req_valid_i = 1'b0;
        #1;
        check_all_zero("mid_reset_async");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check_all_zero("late_rvalid");
        end
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        req_valid_i = 1'b0; st_en_i = 1'b0; addr_i = '0; wdata_i = '0;
        {lb_i, lh_i, lbu_i, lhu_i, sb_i, sh_i} = 6'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        rst_ni = 1'b0;
        test_reset();
        test_store();
        test_load();
        test_misalign();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter Width, default 32, SHALL set the data and address width; only 32 is supported.
REQ-002 clk_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_ni  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 req_valid_i  in  1  SHALL mark a memory instruction; held stable by the core while stall_o=1.
REQ-005 st_en_i  in  1  SHALL select store (1) or load (0).
REQ-006 lb_i, lh_i, lbu_i, lhu_i, sb_i, sh_i  in  1 each  SHALL be the decoded size/sign flags; none set means word.
REQ-007 addr_i  in  Width  SHALL be the byte address, i.e. the ALU result.
REQ-008 wdata_i  in  Width  SHALL be the store data, i.e. rs2.
REQ-009 stall_o  out  1  SHALL freeze the core's PC and pipeline while high.
REQ-010 rdata_o  out  Width  SHALL be the aligned, extended load result, valid while rdata_valid_o=1.
REQ-011 rdata_valid_o  out  1  SHALL pulse for one cycle per completed load.
REQ-012 misalign_o  out  1  SHALL pulse for one cycle per rejected misaligned access.
REQ-013 mem_req_o, mem_we_o  out  1 each; mem_addr_o, mem_wdata_o  out  Width; mem_be_o  out  4  SHALL form the memory request.
REQ-014 mem_gnt_i, mem_rvalid_i  in  1 each; mem_rdata_i  in  Width  SHALL be the memory grant and read-response inputs.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, WAIT_R and DONE.
REQ-016 In IDLE, stall_o SHALL equal req_valid_i; when req_valid_i=1, addr, byte-enables, replicated wdata, we and size SHALL be registered.
REQ-017 From IDLE on an aligned request, the FSM SHALL go to REQ; on a misaligned request it SHALL go to DONE with the error flag set and no memory request.
REQ-018 Misalignment SHALL be: halfword with addr[0]=1, or word with addr[1:0]!=0; byte accesses are never misaligned.
REQ-019 In REQ, mem_req_o=1 SHALL hold with stable address, data and byte-enables until mem_gnt_i=1; on grant a store SHALL go to DONE and a load to WAIT_R.
REQ-020 mem_addr_o SHALL be {addr[31:2],2'b00}.
REQ-021 mem_be_o SHALL be 4'b0001<<addr[1:0] for sb, 4'b0011<<{addr[1],1'b0} for sh, and 4'b1111 for sw.
REQ-022 mem_wdata_o SHALL be wdata[7:0] replicated 4x for sb, wdata[15:0] replicated 2x for sh, and wdata unchanged for sw.
REQ-023 mem_rvalid_i SHALL be sampled only in WAIT_R; on rvalid, the extended data SHALL be registered and the FSM SHALL go to DONE.
REQ-024 The load lane SHALL be mem_rdata_i>>(8*addr[1:0]); lb/lh SHALL sign-extend, lbu/lhu SHALL zero-extend, and a word load SHALL pass unchanged.
REQ-025 Flag priority SHALL be lb>lbu>lh>lhu for loads and sb>sh for stores; load flags SHALL be ignored for stores and vice versa.
REQ-026 In DONE, stall_o SHALL be 0, rdata_valid_o SHALL be 1 only for a good load and misalign_o SHALL be 1 only for an error; the next state SHALL be IDLE unconditionally.
REQ-027 Latency from IDLE acceptance to the DONE pulse SHALL be 2 cycles for a store and 3 cycles for a load, with zero-wait grant and rvalid.
REQ-028 A misaligned access SHALL produce its misalign_o pulse in the cycle after acceptance.

Reset
REQ-029 While rst_ni=0, the state SHALL be IDLE and every output and register SHALL be 0, irrespective of the clock.
REQ-030 Reset mid-transaction SHALL abandon the access; a late mem_rvalid_i after reset SHALL be ignored.

Structure
REQ-031 The package lsu_pkg SHALL hold the state enum, the size enum (BYTE, HALF, WORD), the width constants and the byte-enable function.
REQ-032 The sub-module lsu_align SHALL contain the combinational store replication/byte-enable and load shift/extension logic; the FSM and registers SHALL stay in load_store_unit.

Verification
REQ-033 Store sb, addr=0x1003, wdata=0x000000AB -> mem_be_o=4'b1000, mem_wdata_o=0xABABABAB, mem_addr_o=0x1000, DONE 2 cycles after acceptance.
REQ-034 Load lb, addr=0x2001, mem_rdata_i=0x0000_80FF -> rdata_o=0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-035 Load lh, addr=0x2002, rdata=0x9234_0000 -> 0xFFFF9234; lw with grant withheld 3 cycles and rvalid 2 cycles late -> stall_o held and mem_req_o stable throughout.
REQ-036 Word load at 0x2002 -> misalign_o pulse, mem_req_o never asserted, rdata_valid_o=0.
REQ-037 rst_ni dropped in WAIT_R, then mem_rvalid_i=1 after release -> outputs 0, stall_o=0, no rdata_valid_o pulse.
